// File: rtl/mac_pkg.sv
// Shared defaults and saturation helpers for the multiply-accumulate array.
package mac_pkg;
  localparam int DEF_A_WIDTH   = 8;
  localparam int DEF_B_WIDTH   = 8;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_N_LANES   = 4;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_SHIFT     = 0;

  // Upper (2^(w-1)-1) or lower (-2^(w-1)) clip limit for a w-bit signed result.
  function automatic logic signed [63:0] sat_limit(input int width, input bit upper);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (width - 1);
    return upper ? (lim - 64'sd1) : -lim;
  endfunction
endpackage

// File: rtl/mac_lane.sv
// One MAC lane: product register, wrapping accumulator, shift and saturating output register.
module mac_lane
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_s1_load,
  input  logic                        i_s2_load,
  input  logic                        i_s2_first,
  input  logic                        i_out_load,
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic signed [OUT_WIDTH-1:0] o_result,
  output logic                        o_sat
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam logic signed [63:0] SAT_MAX = sat_limit(OUT_WIDTH, 1'b1);
  localparam logic signed [63:0] SAT_MIN = sat_limit(OUT_WIDTH, 1'b0);

  logic signed [PW-1:0]        r_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [OUT_WIDTH-1:0] r_result;
  logic                        r_sat;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic signed [ACC_WIDTH-1:0] w_shift;
  logic signed [63:0]          w_wide;
  logic signed [OUT_WIDTH-1:0] w_result;
  logic                        w_sat;

  always_comb begin
    w_prod     = PW'(i_a) * PW'(i_b);
    w_acc_next = i_s2_first ? ACC_WIDTH'(r_prod) : r_acc + ACC_WIDTH'(r_prod);
    // Output is taken from the stage-2 accumulator, one edge after it settles.
    w_shift    = r_acc >>> SHIFT;
    w_wide     = 64'(w_shift);
    w_sat      = 1'b0;
    w_result   = OUT_WIDTH'(w_wide);
    if (w_wide > SAT_MAX) begin
      w_result = OUT_WIDTH'(SAT_MAX);
      w_sat    = 1'b1;
    end else if (w_wide < SAT_MIN) begin
      w_result = OUT_WIDTH'(SAT_MIN);
      w_sat    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      if (i_s1_load)  r_prod <= w_prod;
      if (i_s2_load)  r_acc  <= w_acc_next;
      if (i_out_load) begin
        r_result <= w_result;
        r_sat    <= w_sat;
      end
    end
  end

  assign o_result = r_result;
  assign o_sat    = r_sat;
endmodule

// File: rtl/mac_array.sv
// N-lane signed MAC array: product stage, accumulate stage, saturating output register.
// Handshake: a beat transfers on a rising edge with in_valid && in_ready; a result transfers
// with out_valid && out_ready; a held result (out_valid && !out_ready) freezes the whole pipe.
module mac_array
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int N_LANES   = DEF_N_LANES,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [N_LANES*A_WIDTH-1:0]     a_in,
  input  logic [N_LANES*B_WIDTH-1:0]     b_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_LANES*OUT_WIDTH-1:0]   result,
  output logic [N_LANES-1:0]             sat,
  output logic                           busy,
  output logic                           protocol_err
);
  logic r_s1_valid, r_s1_first, r_s1_last;
  logic r_s2_valid, r_s2_last;
  logic r_out_valid, r_open, r_perr;
  logic w_stall, w_accept, w_s2_load, w_out_load;

  assign w_stall    = r_out_valid && !out_ready;
  assign w_accept   = in_valid && !w_stall;
  assign w_s2_load  = !w_stall && r_s1_valid;
  assign w_out_load = !w_stall && r_s2_valid && r_s2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_open      <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_s1_valid  <= in_valid;
        r_s1_first  <= in_first;
        r_s1_last   <= in_last;
        r_s2_valid  <= r_s1_valid;
        r_s2_last   <= r_s1_last;
        r_out_valid <= r_s2_valid && r_s2_last;
      end
      // A first while a vector is still open restarts it and is flagged permanently.
      if (w_accept) begin
        if (in_first && r_open) r_perr <= 1'b1;
        if (in_last)            r_open <= 1'b0;
        else if (in_first)      r_open <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    mac_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT    (SHIFT)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_s1_load (w_accept),
      .i_s2_load (w_s2_load),
      .i_s2_first(r_s1_first),
      .i_out_load(w_out_load),
      .i_a       (a_in[gi*A_WIDTH +: A_WIDTH]),
      .i_b       (b_in[gi*B_WIDTH +: B_WIDTH]),
      .o_result  (result[gi*OUT_WIDTH +: OUT_WIDTH]),
      .o_sat     (sat[gi])
    );
  end

  assign in_ready     = !w_stall;
  assign out_valid    = r_out_valid;
  assign busy         = r_open || r_s1_valid || r_s2_valid;
  assign protocol_err = r_perr;
endmodule

// File: tb/tb_mac_array.sv
// Bench for mac_array: randomized and directed vectors against a plain-arithmetic lane model.
module tb_mac_array;
  localparam int AW   = 8;
  localparam int BW   = 8;
  localparam int ACCW = 32;
  localparam int N    = 4;
  localparam int OW   = 16;
  localparam int SH   = 0;
  localparam int RW   = N*OW + N;

  logic              clk, rst_n;
  logic              in_valid, in_ready, in_first, in_last;
  logic [N*AW-1:0]   a_in;
  logic [N*BW-1:0]   b_in;
  logic              out_valid, out_ready;
  logic [N*OW-1:0]   result;
  logic [N-1:0]      sat;
  logic              busy, protocol_err;

  mac_array #(
    .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW),
    .N_LANES(N), .OUT_WIDTH(OW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat),
    .busy(busy), .protocol_err(protocol_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];
  int last_pop = -10;
  int prev_pop = -20;

  logic signed [ACCW-1:0] m_acc[N];
  bit m_open, m_perr;
  int cur_a[N], cur_b[N];
  bit bp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each lane is an integer running sum, then shift and clip to the output range.
  function automatic logic [RW-1:0] model_out();
    logic [RW-1:0] r;
    longint sh, lo, hi;
    r  = '0;
    hi = (64'sd1 <<< (OW-1)) - 1;
    lo = -(64'sd1 <<< (OW-1));
    for (int i = 0; i < N; i++) begin
      sh = longint'(m_acc[i]) >>> SH;
      if (sh > hi) begin
        r[i*OW +: OW] = OW'(hi);
        r[N*OW + i]   = 1'b1;
      end else if (sh < lo) begin
        r[i*OW +: OW] = OW'(lo);
        r[N*OW + i]   = 1'b1;
      end else begin
        r[i*OW +: OW] = OW'(sh);
      end
    end
    return r;
  endfunction

  task automatic model_accept(input bit f, input bit l);
    int prod;
    if (f && m_open) m_perr = 1'b1;
    for (int i = 0; i < N; i++) begin
      prod = cur_a[i] * cur_b[i];
      if (f) m_acc[i] = ACCW'(prod);
      else   m_acc[i] = m_acc[i] + ACCW'(prod);
    end
    if (l)      m_open = 1'b0;
    else if (f) m_open = 1'b1;
    if (l) exp_q.push_back(model_out());
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_acc[i] = '0;
    m_open = 1'b0;
    m_perr = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge; returns at #1 after the edge that accepted the beat.
  task automatic send_beat(input bit f, input bit l);
    bit ok;
    int guard;
    for (int i = 0; i < N; i++) begin
      a_in[i*AW +: AW] = AW'(cur_a[i]);
      b_in[i*BW +: BW] = BW'(cur_b[i]);
    end
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    ok = 1'b0;
    guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", guard);
    end else begin
      model_accept(f, l);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) begin
      cur_a[i] = int'($urandom_range(0, 255)) - 128;
      cur_b[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic set_lane0(input int a, input int b);
    rand_lanes();
    cur_a[0] = a;
    cur_b[0] = b;
  endtask

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < N; i++) begin
      cur_a[i] = a;
      cur_b[i] = b;
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: result %0h with empty queue", {sat, result});
      end else begin
        check("result_sat", 128'({sat, result}), 128'(exp_q.pop_front()));
        prev_pop = last_pop;
        last_pop = cyc;
      end
    end
  end

  // Random backpressure, active only in the random phase.
  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    a_in = '0;
    b_in = '0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_perr", 128'(protocol_err), 128'd0);
    check("rst_result_sat", 128'({sat, result}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    // Four-beat vector on lane 0 and its latency.
    set_lane0(3, 2);   send_beat(1'b1, 1'b0);
    set_lane0(-1, 5);  send_beat(1'b0, 1'b0);
    set_lane0(4, -2);  send_beat(1'b0, 1'b0);
    set_lane0(1, 10);  send_beat(1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("busy_in_flight", 128'(busy), 128'd1);
    @(negedge clk);
    check("lat_k1_no_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    check("lat_k2_valid", 128'(out_valid), 128'd1);
    @(posedge clk); #1;
    drain(50);

    // Saturation in both directions.
    set_all(127, 127);
    send_beat(1'b1, 1'b0); send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0); send_beat(1'b0, 1'b1);
    set_all(-128, 127);
    send_beat(1'b1, 1'b0); send_beat(1'b0, 1'b0); send_beat(1'b0, 1'b1);
    idle();
    drain(50);

    // Back-to-back single-beat vectors.
    set_lane0(2, 3);   send_beat(1'b1, 1'b1);
    set_lane0(-4, 5);  send_beat(1'b1, 1'b1);
    idle();
    drain(50);
    check("b2b_consecutive", 128'(last_pop - prev_pop), 128'd1);

    // Held result: stall for five cycles while another beat waits.
    out_ready = 1'b0;
    rand_lanes();
    send_beat(1'b1, 1'b1);
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("stall_pending", 128'(out_valid), 128'd1);
    rand_lanes();
    fork
      send_beat(1'b1, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 128'(in_ready), 128'd0);
          check("stall_stable", 128'({sat, result}), 128'(exp_q[0]));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle();
    drain(50);

    // Restarted vector: only the second vector's sum survives.
    check("perr_clear", 128'(protocol_err), 128'd0);
    rand_lanes(); send_beat(1'b1, 1'b0);
    rand_lanes(); send_beat(1'b0, 1'b0);
    rand_lanes(); send_beat(1'b1, 1'b0);
    rand_lanes(); send_beat(1'b0, 1'b1);
    idle();
    drain(50);
    check("perr_set", 128'(protocol_err), 128'(m_perr));
    repeat (3) @(posedge clk);
    #1;
    check("perr_sticky", 128'(protocol_err), 128'd1);

    // Reset in the middle of an open vector.
    rand_lanes(); send_beat(1'b1, 1'b0);
    rand_lanes(); send_beat(1'b0, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_perr", 128'(protocol_err), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    set_all(1, 1);
    send_beat(1'b1, 1'b1);
    idle();
    drain(50);

    // Randomized vectors under random backpressure.
    bp_en = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          idle();
          @(posedge clk); #1;
        end
        rand_lanes();
        send_beat(k == 0, k == len - 1);
      end
    end
    idle();
    bp_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(200);
    check("final_perr", 128'(protocol_err), 128'(m_perr));
    check("final_busy", 128'(busy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
